sm_color_sensor_emulator: RTL

//  Emulates the TCS3200 colour sensor (transmitter side of the sensor link) for bench/HIL use.

---
 rtl/sm_color_sensor_emulator.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sm_color_sensor_emulator.sv
// sm_color_sensor_emulator: TCS3200 colour-sensor transmitter emulation.
// Decodes S0..S3, produces a square wave whose half-period is the stored
// per-filter table entry times the frequency-scale factor (1/5/50).
// The half-period table can be rewritten at run time through cfg_*.
// Optional build macro SM_EMU_JITTER_EN: adds 0..7 cycles of LFSR jitter
// to every half-period (both halves of one period share the same value).
module sm_color_sensor_emulator #(
  parameter int unsigned DEF_RED   = 235,
  parameter int unsigned DEF_BLUE  = 420,
  parameter int unsigned DEF_GREEN = 260,
  parameter int unsigned DEF_CLEAR = 127
) (
  input  logic        clk_50M,
  input  logic        reset,
  input  logic        S0,
  input  logic        S1,
  input  logic        S2,
  input  logic        S3,
  input  logic        cfg_wr,
  input  logic [1:0]  cfg_sel,
  input  logic [20:0] cfg_data,
  output logic        out,
  output logic        active,
  output logic [1:0]  cur_filter
);

  typedef enum logic [1:0] {OFF = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_e;

  state_e           state_q;
  logic [26:0]      hc_q;
  logic [26:0]      hp_q;
  logic [3:0][20:0] tbl_q;
  logic             out_q;
  logic             active_q;
  logic [1:0]       filt_q;

  logic             pd;
  logic [1:0]       filt_sel;
  logic [5:0]       scale_k;
  logic [26:0]      hp_base;
  logic [26:0]      hp_new;
  logic             latch;

  // Decode power-down, scale factor and filter index from the select pins
  always_comb begin
    pd       = ({S0, S1} == 2'b00);
    scale_k  = 6'd0;
    filt_sel = 2'd0;
    case ({S0, S1})
      2'b01:   scale_k = 6'd50;
      2'b10:   scale_k = 6'd5;
      2'b11:   scale_k = 6'd1;
      default: scale_k = 6'd0;
    endcase
    case ({S2, S3})
      2'b00:   filt_sel = 2'd0;  // red
      2'b01:   filt_sel = 2'd1;  // blue
      2'b11:   filt_sel = 2'd2;  // green
      default: filt_sel = 2'd3;  // clear
    endcase
  end

  // 21-bit entry times at most 50 fits in 27 bits, so no overflow handling
  assign hp_base = 27'(tbl_q[filt_sel]) * 27'(scale_k);

  // A new period starts on every entry to HIGH: from OFF, or at the end of LOW
  assign latch = !pd && ((state_q == OFF) || ((state_q == LOW) && (hc_q == 27'd0)));

`ifdef SM_EMU_JITTER_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  // Taps for x^16+x^14+x^13+x^11+1, shifting toward the MSB
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  // Jitter uses the value held before this latch's step
  assign hp_new  = hp_base + 27'(lfsr_q[2:0]);

  // LFSR advances once per latch so the jitter sequence is reproducible
  always_ff @(posedge clk_50M) begin
    if (reset)      lfsr_q <= 16'hACE1;
    else if (latch) lfsr_q <= {lfsr_q[14:0], lfsr_fb};
  end
`else
  assign hp_new = hp_base;
`endif

  // Half-period table; a write on the latch cycle is seen only by later latches
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      tbl_q[0] <= 21'(DEF_RED);
      tbl_q[1] <= 21'(DEF_BLUE);
      tbl_q[2] <= 21'(DEF_GREEN);
      tbl_q[3] <= 21'(DEF_CLEAR);
    end else if (cfg_wr) begin
      tbl_q[cfg_sel] <= (cfg_data == 21'd0) ? 21'd1 : cfg_data;
    end
  end

  // Waveform FSM with registered out/active/cur_filter
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state_q  <= OFF;
      out_q    <= 1'b0;
      active_q <= 1'b0;
      filt_q   <= 2'd0;
      hc_q     <= 27'd0;
      hp_q     <= 27'd0;
    end else if (pd) begin
      // Power-down aborts any period immediately
      state_q  <= OFF;
      out_q    <= 1'b0;
      active_q <= 1'b0;
    end else if (latch) begin
      state_q  <= HIGH;
      out_q    <= 1'b1;
      active_q <= 1'b1;
      filt_q   <= filt_sel;
      hp_q     <= hp_new;
      hc_q     <= hp_new - 27'd1;
    end else begin
      case (state_q)
        HIGH: begin
          if (hc_q == 27'd0) begin
            state_q <= LOW;
            out_q   <= 1'b0;
            hc_q    <= hp_q - 27'd1;
          end else begin
            hc_q    <= hc_q - 27'd1;
          end
        end
        LOW: begin
          hc_q <= hc_q - 27'd1;
        end
        default: begin
          state_q  <= OFF;
          out_q    <= 1'b0;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign out        = out_q;
  assign active     = active_q;
  assign cur_filter = filt_q;

endmodule
